// File: rtl/lookup3_seq.sv
// lookup3_seq -- sequential Bob Jenkins lookup3 "hashlittle" engine.
//
// A hash is requested with a one-cycle start pulse carrying the key length
// in bytes and a 32-bit seed. Key words are then pulled over a valid/ready
// handshake, little-endian within each word. Every full 12-byte block that is
// not the last one goes through the 6-line mix (one line per cycle). The last
// block (1..12 bytes, tail bytes masked to zero) goes through the 7-line final
// mix, and the result is published on hash with a one-cycle hvalid pulse.
//
// Ports
//   clk      in   clock, all state on the rising edge
//   res      in   asynchronous active-low reset
//   start    in   begin a hash; only accepted while idle
//   len      in   key length in bytes, sampled with an accepted start
//   initval  in   seed, sampled with an accepted start
//   kvalid   in   key word valid
//   kdata    in   key word, byte n at bits [8*(n%4)+7 : 8*(n%4)]
//   kready   out  key word wanted (only while loading)
//   busy     out  engine is not idle
//   hash     out  last result, held until the next result
//   hvalid   out  one-cycle pulse when hash updates
//
// Latency from accepted start to hvalid with no stalls:
// W + 6*M + 8 cycles (W key words, M mix blocks), 1 cycle for len = 0.

module lookup3_seq #(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      initval,
    input  logic             kvalid,
    input  logic [31:0]      kdata,
    output logic             kready,
    output logic             busy,
    output logic [31:0]      hash,
    output logic             hvalid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MIX   = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [31:0] rot(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      a_q, b_q, c_q, a_d, b_d, c_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       slot_q, slot_d;
    logic [2:0]       step_q, step_d;
    logic [31:0]      hash_q, hash_d;
    logic             hvalid_q, hvalid_d;

    logic [31:0]      seed;
    logic [LEN_W-1:0] avail;
    logic             last_blk;
    logic             last_word;
    logic [31:0]      kword;

    assign seed = 32'hDEADBEEF + 32'(len) + initval;

    // Bytes still owed counting from the current slot; only meaningful in the
    // last block, where it never underflows because slot*4 < rem there.
    assign avail     = rem_q - LEN_W'({slot_q, 2'b00});
    assign last_blk  = (rem_q <= LEN_W'(12));
    assign last_word = last_blk && (avail <= LEN_W'(4));

    // Partial last word: bytes past the key end are zeroed, whatever the
    // source left in them.
    always_comb begin
        kword = kdata;
        if (last_blk) begin
            if (avail == LEN_W'(1))      kword = {24'h0, kdata[7:0]};
            else if (avail == LEN_W'(2)) kword = {16'h0, kdata[15:0]};
            else if (avail == LEN_W'(3)) kword = {8'h0,  kdata[23:0]};
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        rem_d    = rem_q;
        slot_d   = slot_q;
        step_d   = step_q;
        hash_d   = hash_q;
        hvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = seed;
                    b_d     = seed;
                    c_d     = seed;
                    rem_d   = len;
                    slot_d  = 2'd0;
                    step_d  = 3'd0;
                    state_d = (len != '0) ? LOAD : DONE;
                end
            end

            LOAD: begin
                if (kvalid) begin
                    case (slot_q)
                        2'd0:    a_d = a_q + kword;
                        2'd1:    b_d = b_q + kword;
                        default: c_d = c_q + kword;
                    endcase
                    if (last_word) begin
                        slot_d  = 2'd0;
                        step_d  = 3'd0;
                        state_d = FINAL;
                    end else if (slot_q == 2'd2) begin
                        // Full block with more key behind it: mix, then continue.
                        rem_d   = rem_q - LEN_W'(12);
                        slot_d  = 2'd0;
                        step_d  = 3'd0;
                        state_d = MIX;
                    end else begin
                        slot_d  = slot_q + 2'd1;
                    end
                end
            end

            MIX: begin
                case (step_q)
                    3'd0: begin a_d = (a_q - c_q) ^ rot(c_q, 4);  c_d = c_q + b_q; end
                    3'd1: begin b_d = (b_q - a_q) ^ rot(a_q, 6);  a_d = a_q + c_q; end
                    3'd2: begin c_d = (c_q - b_q) ^ rot(b_q, 8);  b_d = b_q + a_q; end
                    3'd3: begin a_d = (a_q - c_q) ^ rot(c_q, 16); c_d = c_q + b_q; end
                    3'd4: begin b_d = (b_q - a_q) ^ rot(a_q, 19); a_d = a_q + c_q; end
                    default: begin c_d = (c_q - b_q) ^ rot(b_q, 4); b_d = b_q + a_q; end
                endcase
                step_d = step_q + 3'd1;
                if (step_q == 3'd5) begin
                    step_d  = 3'd0;
                    state_d = LOAD;
                end
            end

            FINAL: begin
                case (step_q)
                    3'd0: c_d = (c_q ^ b_q) - rot(b_q, 14);
                    3'd1: a_d = (a_q ^ c_q) - rot(c_q, 11);
                    3'd2: b_d = (b_q ^ a_q) - rot(a_q, 25);
                    3'd3: c_d = (c_q ^ b_q) - rot(b_q, 16);
                    3'd4: a_d = (a_q ^ c_q) - rot(c_q, 4);
                    3'd5: b_d = (b_q ^ a_q) - rot(a_q, 14);
                    default: c_d = (c_q ^ b_q) - rot(b_q, 24);
                endcase
                step_d = step_q + 3'd1;
                if (step_q == 3'd6) begin
                    step_d  = 3'd0;
                    state_d = DONE;
                end
            end

            DONE: begin
                hash_d   = c_q;
                hvalid_d = 1'b1;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            rem_q    <= '0;
            slot_q   <= '0;
            step_q   <= '0;
            hash_q   <= '0;
            hvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            rem_q    <= rem_d;
            slot_q   <= slot_d;
            step_q   <= step_d;
            hash_q   <= hash_d;
            hvalid_q <= hvalid_d;
        end
    end

    assign kready = (state_q == LOAD);
    assign busy   = (state_q != IDLE);
    assign hash   = hash_q;
    assign hvalid = hvalid_q;

endmodule

// File: tb/tb_lookup3_seq.sv
// tb_lookup3_seq -- scoreboard bench for lookup3_seq.
//
// The driver issues a hash request, pushes the expected hash (and, for
// stall-free runs, the cycle at which hvalid must appear) into a queue, then
// feeds key words. A separate monitor pops and compares whenever hvalid is
// seen. Expected hashes are published lookup3 values or a byte-oriented
// software hashlittle reference.

module tb_lookup3_seq;

    localparam int LEN_W = 32;

    logic             clk;
    logic             res;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      initval;
    logic             kvalid;
    logic [31:0]      kdata;
    logic             kready;
    logic             busy;
    logic [31:0]      hash;
    logic             hvalid;

    lookup3_seq #(.LEN_W(LEN_W)) dut (
        .clk     (clk),
        .res     (res),
        .start   (start),
        .len     (len),
        .initval (initval),
        .kvalid  (kvalid),
        .kdata   (kdata),
        .kready  (kready),
        .busy    (busy),
        .hash    (hash),
        .hvalid  (hvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hash;
        int          exp_cyc;   // -1 when latency is not checked
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          words_taken = 0;
    logic [7:0]  key [0:63];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (res && kvalid && kready) words_taken <= words_taken + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- software reference (hashlittle, byte view) ----------
    function automatic logic [31:0] rot(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] le32(input int off);
        return {key[off+3], key[off+2], key[off+1], key[off]};
    endfunction

    function automatic logic [31:0] ref_hash(input int n, input logic [31:0] iv);
        logic [31:0] a, b, c;
        logic [31:0] w [3];
        int off, r;
        a = 32'hDEADBEEF + 32'(n) + iv;
        b = a;
        c = a;
        if (n == 0) return c;
        off = 0;
        r = n;
        while (r > 12) begin
            a += le32(off); b += le32(off + 4); c += le32(off + 8);
            a -= c; a ^= rot(c, 4);  c += b;
            b -= a; b ^= rot(a, 6);  a += c;
            c -= b; c ^= rot(b, 8);  b += a;
            a -= c; a ^= rot(c, 16); c += b;
            b -= a; b ^= rot(a, 19); a += c;
            c -= b; c ^= rot(b, 4);  b += a;
            r -= 12;
            off += 12;
        end
        for (int i = 0; i < 3; i++) w[i] = 32'h0;
        for (int i = 0; i < r; i++) w[i/4] |= 32'(key[off+i]) << (8 * (i % 4));
        a += w[0]; b += w[1]; c += w[2];
        c ^= b; c -= rot(b, 14);
        a ^= c; a -= rot(c, 11);
        b ^= a; b -= rot(a, 25);
        c ^= b; c -= rot(b, 16);
        a ^= c; a -= rot(c, 4);
        b ^= a; b -= rot(a, 14);
        c ^= b; c -= rot(b, 24);
        return c;
    endfunction

    // Bytes past the key end carry junk so masking is exercised.
    function automatic logic [31:0] word_at(input int idx, input int n);
        logic [31:0] w;
        w = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (4*idx + b < n) w[8*b +: 8] = key[4*idx + b];
            else               w[8*b +: 8] = 8'hA5;
        end
        return w;
    endfunction

    task automatic load_key(input string s);
        for (int i = 0; i < 64; i++) key[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) key[i] = s[i];
    endtask

    // ---------------- monitor ---------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (res) begin
            if (!busy) check("kready_while_idle", 32'(kready), 32'h0);
            if (hvalid) begin
                if (sb.size() == 0) begin
                    check("hvalid_without_request", 32'(hvalid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_hash"}, hash, e.hash);
                    if (e.exp_cyc >= 0) check({e.tag, "_latency"}, 32'(cyc), 32'(e.exp_cyc));
                end
            end
        end
    end

    // ---------------- driver ----------------------------------------------
    // poke_at >= 0 pulses a bogus start on that feed iteration (engine busy).
    task automatic run_hash(input string tag, input int n, input logic [31:0] iv,
                            input logic [31:0] exp, input bit stall, input int poke_at);
        int   nw, m, lat, base, idx, it, b;
        bit   fire;
        exp_t e;
        nw  = (n + 3) / 4;
        m   = (n > 0) ? (n - 1) / 12 : 0;
        lat = (n == 0) ? 1 : nw + 6*m + 8;

        b = 0;
        while (busy && b < 200) begin @(negedge clk); b++; end
        check({tag, "_idle_before_start"}, 32'(busy), 32'h0);

        @(negedge clk);
        start   = 1'b1;
        len     = LEN_W'(n);
        initval = iv;
        base    = words_taken;
        @(posedge clk);
        #1;
        start     = 1'b0;
        e.hash    = exp;
        e.exp_cyc = stall ? -1 : cyc + lat;
        e.tag     = tag;
        sb.push_back(e);

        idx = 0;
        it  = 0;
        while (idx < nw && it < 2000) begin
            kvalid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            kdata  = word_at(idx, n);
            if (it == poke_at) begin
                start   = 1'b1;
                len     = LEN_W'(5);
                initval = 32'h0000_1234;
            end
            @(negedge clk);
            fire = kvalid && kready;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (fire) idx++;
            it++;
        end
        kvalid = 1'b0;
        kdata  = 32'hFFFF_FFFF;
        check({tag, "_words_fed"}, 32'(idx), 32'(nw));

        b = 0;
        while (sb.size() != 0 && b < 300) begin @(posedge clk); b++; end
        check({tag, "_result_seen"}, 32'(sb.size()), 32'h0);
        sb.delete();
        check({tag, "_words_consumed"}, 32'(words_taken - base), 32'(nw));
    endtask

    localparam string FOUR = "Four score and seven years ago";

    initial begin
        res     = 1'b0;
        start   = 1'b0;
        len     = '0;
        initval = 32'h0;
        kvalid  = 1'b0;
        kdata   = 32'h0;
        load_key(FOUR);

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_kready", 32'(kready), 32'h0);
        check("reset_hvalid", 32'(hvalid), 32'h0);
        check("reset_hash",   hash,        32'h0);
        @(negedge clk);
        res = 1'b1;

        run_hash("len0_iv0",       0,  32'h0,        32'hDEADBEEF, 1'b0, -1);
        run_hash("len0_ivdeadbeef",0,  32'hDEADBEEF, 32'hBD5B7DDE, 1'b0, -1);
        run_hash("four_iv0",       30, 32'h0,        32'h17770551, 1'b0, -1);
        run_hash("four_iv1",       30, 32'h1,        32'hCD628161, 1'b0, -1);
        run_hash("four_stall",     30, 32'h0,        32'h17770551, 1'b1, -1);
        run_hash("four_stall_iv1", 30, 32'h1,        32'hCD628161, 1'b1, -1);

        run_hash("key12",          12, 32'h0,        ref_hash(12, 32'h0),        1'b0, 2);
        run_hash("key13",          13, 32'h0,        ref_hash(13, 32'h0),        1'b0, 5);
        run_hash("key13_stall",    13, 32'h0BAD_F00D, ref_hash(13, 32'h0BAD_F00D), 1'b1, 3);
        run_hash("key24",          24, 32'h0,        ref_hash(24, 32'h0),        1'b0, -1);
        run_hash("key5_partial",   5,  32'h9E3779B9, ref_hash(5, 32'h9E3779B9),  1'b0, -1);
        run_hash("key27_partial",  27, 32'h0,        ref_hash(27, 32'h0),        1'b1, -1);

        // Reset while mixing the first block of a 30-byte key.
        @(negedge clk);
        start   = 1'b1;
        len     = LEN_W'(30);
        initval = 32'h0;
        @(posedge clk);
        #1;
        start  = 1'b0;
        kvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            kdata = word_at(i, 30);
            @(posedge clk);
            #1;
        end
        kvalid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(busy), 32'h1);
        res = 1'b0;
        #1;
        check("midreset_busy",   32'(busy),   32'h0);
        check("midreset_kready", 32'(kready), 32'h0);
        check("midreset_hvalid", 32'(hvalid), 32'h0);
        check("midreset_hash",   hash,        32'h0);
        @(negedge clk);
        res = 1'b1;
        run_hash("post_reset_len0", 0, 32'h0, 32'hDEADBEEF, 1'b0, -1);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lookup3_seq.md
LOOKUP3_SEQ -- requirements
Module: lookup3_seq

Interface
REQ-001 SHALL have parameter: LEN_W, 32, width of byte-length input (8..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state on posedge.
REQ-003 SHALL have port: res  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a hash; accepted only in IDLE.
REQ-005 SHALL have port: len  input  LEN_W  key length in bytes, sampled with accepted start.
REQ-006 SHALL have port: initval  input  32  seed, sampled with accepted start.
REQ-007 SHALL have port: kvalid  input  1  key word valid.
REQ-008 SHALL have port: kdata  input  32  key word; byte n at bits [8*(n%4)+7:8*(n%4)] (little-endian).
REQ-009 SHALL have port: kready  output  1  high only in LOAD while a word is needed.
REQ-010 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port: hash  output  32  result, held until next accepted start.
REQ-012 SHALL have port: hvalid  output  1  one-cycle pulse when hash updates.

Function
REQ-013 SHALL implement states IDLE, LOAD, MIX, FINAL, DONE.
REQ-014 SHALL on accepted start set a=b=c=32'hDEADBEEF+len+initval (mod 2^32), rem=len, slot=0; go LOAD if len>0, else DONE.
REQ-015 SHALL in LOAD accept a word on kvalid&&kready and add it (mod 2^32) to a, b, c for slot 0, 1, 2; slot increments per word.
REQ-016 SHALL, when rem<=12, mask bytes beyond rem in the last block (keep only the low (rem-4*slot) bytes of a partial word) and not request words past ceil(rem/4).
REQ-017 SHALL, after slot 2 with rem>12, go MIX, rem-=12, slot=0; after the last needed word with rem<=12, go FINAL.
REQ-018 SHALL in MIX execute one lookup3 mix line per cycle, 6 cycles: (a-=c;a^=rot(c,4);c+=b),(b-=a;b^=rot(a,6);a+=c),(c-=b;c^=rot(b,8);b+=a),(a-=c;a^=rot(c,16);c+=b),(b-=a;b^=rot(a,19);a+=c),(c-=b;c^=rot(b,4);b+=a); then LOAD.
REQ-019 SHALL in FINAL execute one line per cycle, 7 cycles: c^=b;c-=rot(b,14) | a^=c;a-=rot(c,11) | b^=a;b-=rot(a,25) | c^=b;c-=rot(b,16) | a^=c;a-=rot(c,4) | b^=a;b-=rot(a,14) | c^=b;c-=rot(b,24); then DONE.
REQ-020 SHALL define rot(x,k) as 32-bit left rotate; all arithmetic 32-bit, wrap-around.
REQ-021 SHALL in DONE set hash=c, pulse hvalid one cycle, return IDLE next cycle.
REQ-022 SHALL hold key words stalled indefinitely in LOAD with no state change while kvalid=0.
REQ-023 SHALL ignore start while busy; SHALL ignore kvalid outside LOAD.
REQ-024 SHALL give latency from accepted start to hvalid of W+6*M+7+1 cycles with no stalls (W words, M mix blocks), 1 cycle for len=0.
REQ-025 SHALL treat len exactly 12*k as k-1 mix blocks plus a full 12-byte final block (no mix before final on last block).

Reset
REQ-026 SHALL on res low, at any time including mid-hash, immediately force IDLE, busy=0, kready=0, hvalid=0, hash=0, a=b=c=0, rem=0, slot=0.
REQ-027 SHALL discard any partial hash interrupted by reset; first start after res high begins cleanly.

Verification
REQ-028 SHALL pass: len=0, initval=0 -> hvalid one cycle after start, hash=32'hDEADBEEF.
REQ-029 SHALL pass: len=0, initval=32'hDEADBEEF -> hash=32'hBD5B7DDE.
REQ-030 SHALL pass: "Four score and seven years ago" (30 bytes, 8 words), initval=0 -> hash=32'h17770551; initval=1 -> hash=32'hCD628161; latency 8+12+7+1 cycles without stalls.
REQ-031 SHALL pass: same 30-byte key with random kvalid gaps -> identical hash; kready never high outside LOAD; exactly 8 words consumed.
REQ-032 SHALL pass: res asserted during MIX -> all outputs 0 same cycle; following len=0 hash gives 32'hDEADBEEF.
REQ-033 SHALL pass: start pulsed while busy -> ignored, in-flight result unchanged; 12- and 13-byte keys checked against software lookup3 hashlittle.
